// File: rtl/alu_arbiter_if.sv
// Request/response/ALU bundle shared between the issue-side requesters and alu_arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface alu_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int CTRL_WIDTH = 4
);
    logic                  req0_valid;
    logic                  req0_ready;
    logic [DATA_WIDTH-1:0] req0_op1;
    logic [DATA_WIDTH-1:0] req0_op2;
    logic [CTRL_WIDTH-1:0] req0_ctrl;
    logic                  req1_valid;
    logic                  req1_ready;
    logic [DATA_WIDTH-1:0] req1_op1;
    logic [DATA_WIDTH-1:0] req1_op2;
    logic [CTRL_WIDTH-1:0] req1_ctrl;
    logic                  rsp0_valid;
    logic                  rsp0_ready;
    logic [DATA_WIDTH-1:0] rsp0_data;
    logic                  rsp1_valid;
    logic                  rsp1_ready;
    logic [DATA_WIDTH-1:0] rsp1_data;
    logic [DATA_WIDTH-1:0] alu_op1;
    logic [DATA_WIDTH-1:0] alu_op2;
    logic [CTRL_WIDTH-1:0] alu_ctrl;
    logic [DATA_WIDTH-1:0] alu_result;

    modport slave (
        input  req0_valid, req0_op1, req0_op2, req0_ctrl,
        input  req1_valid, req1_op1, req1_op2, req1_ctrl,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp0_data, rsp1_valid, rsp1_data,
        input  rsp0_ready, rsp1_ready,
        output alu_op1, alu_op2, alu_ctrl,
        input  alu_result
    );

    modport master (
        output req0_valid, req0_op1, req0_op2, req0_ctrl,
        output req1_valid, req1_op1, req1_op2, req1_ctrl,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp0_data, rsp1_valid, rsp1_data,
        output rsp0_ready, rsp1_ready,
        input  alu_op1, alu_op2, alu_ctrl,
        output alu_result
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters, with a
// one-entry result slot per requester. Define ALU_ARB_PERF_EN for grant/stall counters.
module alu_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int CTRL_WIDTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
`ifdef ALU_ARB_PERF_EN
    output logic [15:0] grant0_cnt,
    output logic [15:0] grant1_cnt,
    output logic [15:0] stall_cnt,
`endif
    alu_arbiter_if.slave bus
);
    logic                  elig0_s, elig1_s;
    logic                  grant0_s, grant1_s;
    logic                  prio_q, prio_d;
    logic                  rsp0_valid_q, rsp0_valid_d;
    logic                  rsp1_valid_q, rsp1_valid_d;
    logic [DATA_WIDTH-1:0] rsp0_data_q, rsp0_data_d;
    logic [DATA_WIDTH-1:0] rsp1_data_q, rsp1_data_d;

    // A slot can take a new result if it is empty or being drained this cycle.
    assign elig0_s = bus.req0_valid && (!rsp0_valid_q || bus.rsp0_ready);
    assign elig1_s = bus.req1_valid && (!rsp1_valid_q || bus.rsp1_ready);

    // Arbitration and priority update.
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        prio_d   = prio_q;
        if (elig0_s && elig1_s) begin
            grant0_s = !prio_q;
            grant1_s = prio_q;
        end else begin
            grant0_s = elig0_s;
            grant1_s = elig1_s;
        end
        if (grant0_s) begin
            prio_d = 1'b1;
        end else if (grant1_s) begin
            prio_d = 1'b0;
        end else begin
            prio_d = prio_q;
        end
    end

    // ALU operand mux, parked at zero when idle.
    always_comb begin
        bus.alu_op1  = {DATA_WIDTH{1'b0}};
        bus.alu_op2  = {DATA_WIDTH{1'b0}};
        bus.alu_ctrl = {CTRL_WIDTH{1'b0}};
        if (grant0_s) begin
            bus.alu_op1  = bus.req0_op1;
            bus.alu_op2  = bus.req0_op2;
            bus.alu_ctrl = bus.req0_ctrl;
        end else if (grant1_s) begin
            bus.alu_op1  = bus.req1_op1;
            bus.alu_op2  = bus.req1_op2;
            bus.alu_ctrl = bus.req1_ctrl;
        end else begin
            bus.alu_op1  = {DATA_WIDTH{1'b0}};
            bus.alu_op2  = {DATA_WIDTH{1'b0}};
            bus.alu_ctrl = {CTRL_WIDTH{1'b0}};
        end
    end

    // Response slots: a refill wins over a drain so back-to-back results keep valid high.
    always_comb begin
        rsp0_valid_d = rsp0_valid_q;
        rsp0_data_d  = rsp0_data_q;
        rsp1_valid_d = rsp1_valid_q;
        rsp1_data_d  = rsp1_data_q;
        if (grant0_s) begin
            rsp0_valid_d = 1'b1;
            rsp0_data_d  = bus.alu_result;
        end else if (bus.rsp0_ready) begin
            rsp0_valid_d = 1'b0;
        end else begin
            rsp0_valid_d = rsp0_valid_q;
        end
        if (grant1_s) begin
            rsp1_valid_d = 1'b1;
            rsp1_data_d  = bus.alu_result;
        end else if (bus.rsp1_ready) begin
            rsp1_valid_d = 1'b0;
        end else begin
            rsp1_valid_d = rsp1_valid_q;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q       <= 1'b0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp0_data_q  <= {DATA_WIDTH{1'b0}};
            rsp1_data_q  <= {DATA_WIDTH{1'b0}};
        end else begin
            prio_q       <= prio_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp1_valid_q <= rsp1_valid_d;
            rsp0_data_q  <= rsp0_data_d;
            rsp1_data_q  <= rsp1_data_d;
        end
    end

    assign bus.req0_ready = grant0_s;
    assign bus.req1_ready = grant1_s;
    assign bus.rsp0_valid = rsp0_valid_q;
    assign bus.rsp1_valid = rsp1_valid_q;
    assign bus.rsp0_data  = rsp0_data_q;
    assign bus.rsp1_data  = rsp1_data_q;

`ifdef ALU_ARB_PERF_EN
    logic [15:0] grant0_cnt_q, grant0_cnt_d;
    logic [15:0] grant1_cnt_q, grant1_cnt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic        stall_s;

    function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
        if (en && (v != 16'hFFFF)) begin
            return v + 16'd1;
        end else begin
            return v;
        end
    endfunction

    assign stall_s = (bus.req0_valid && !grant0_s) || (bus.req1_valid && !grant1_s);

    // Saturating counter next-state.
    always_comb begin
        grant0_cnt_d = sat_inc(grant0_cnt_q, grant0_s);
        grant1_cnt_d = sat_inc(grant1_cnt_q, grant1_s);
        stall_cnt_d  = sat_inc(stall_cnt_q, stall_s);
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant0_cnt_q <= 16'd0;
            grant1_cnt_q <= 16'd0;
            stall_cnt_q  <= 16'd0;
        end else begin
            grant0_cnt_q <= grant0_cnt_d;
            grant1_cnt_q <= grant1_cnt_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign grant0_cnt = grant0_cnt_q;
    assign grant1_cnt = grant1_cnt_q;
    assign stall_cnt  = stall_cnt_q;
`endif
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: expected results are queued per requester and a
// negedge monitor pops/compares them on each response handshake.
module tb_alu_arbiter;
    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;
    logic [31:0] q0[$];
    logic [31:0] q1[$];

    alu_arbiter_if #(.DATA_WIDTH(32), .CTRL_WIDTH(4)) bus ();

`ifdef ALU_ARB_PERF_EN
    logic [15:0] grant0_cnt, grant1_cnt, stall_cnt;
    alu_arbiter #(.DATA_WIDTH(32), .CTRL_WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .grant0_cnt(grant0_cnt), .grant1_cnt(grant1_cnt), .stall_cnt(stall_cnt),
        .bus(bus)
    );
`else
    alu_arbiter #(.DATA_WIDTH(32), .CTRL_WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLTU, 7 SLL, 8 SRL, 9 SRA, 10/11 pass.
    always_comb begin
        case (bus.alu_ctrl)
            4'd0:    bus.alu_result = bus.alu_op1 + bus.alu_op2;
            4'd1:    bus.alu_result = bus.alu_op1 - bus.alu_op2;
            4'd2:    bus.alu_result = bus.alu_op1 & bus.alu_op2;
            4'd3:    bus.alu_result = bus.alu_op1 | bus.alu_op2;
            4'd4:    bus.alu_result = bus.alu_op1 ^ bus.alu_op2;
            4'd5:    bus.alu_result = {31'd0, $signed(bus.alu_op1) < $signed(bus.alu_op2)};
            4'd6:    bus.alu_result = {31'd0, bus.alu_op1 < bus.alu_op2};
            4'd7:    bus.alu_result = bus.alu_op1 << bus.alu_op2[4:0];
            4'd8:    bus.alu_result = bus.alu_op1 >> bus.alu_op2[4:0];
            4'd9:    bus.alu_result = $signed(bus.alu_op1) >>> bus.alu_op2[4:0];
            4'd10:   bus.alu_result = bus.alu_op2;
            4'd11:   bus.alu_result = bus.alu_op1;
            default: bus.alu_result = 32'd0;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive0(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
        bus.req0_valid = v; bus.req0_op1 = a; bus.req0_op2 = b; bus.req0_ctrl = c;
    endtask

    task automatic drive1(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
        bus.req1_valid = v; bus.req1_op1 = a; bus.req1_op2 = b; bus.req1_ctrl = c;
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.rsp0_valid && bus.rsp0_ready) begin
                if (q0.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL rsp0_unexpected: got %0h expected no response", bus.rsp0_data);
                end else begin
                    chk("rsp0_data", bus.rsp0_data, q0.pop_front());
                end
            end
            if (bus.rsp1_valid && bus.rsp1_ready) begin
                if (q1.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL rsp1_unexpected: got %0h expected no response", bus.rsp1_data);
                end else begin
                    chk("rsp1_data", bus.rsp1_data, q1.pop_front());
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_vec = 0; n_err = 0;
        rst_n = 1'b0;
        drive0(1'b0, 32'd0, 32'd0, 4'd0);
        drive1(1'b0, 32'd0, 32'd0, 4'd0);
        bus.rsp0_ready = 1'b0; bus.rsp1_ready = 1'b0;
        #3;
        chk("rst_rsp0_valid", {31'd0, bus.rsp0_valid}, 32'd0);
        chk("rst_rsp1_valid", {31'd0, bus.rsp1_valid}, 32'd0);
        chk("rst_rsp0_data", bus.rsp0_data, 32'd0);
        chk("rst_rsp1_data", bus.rsp1_data, 32'd0);
        chk("rst_req0_ready", {31'd0, bus.req0_ready}, 32'd0);
        chk("rst_alu_op1", bus.alu_op1, 32'd0);
        rst_n = 1'b1;

        // Single request: 5 - 3.
        tick();
        drive0(1'b1, 32'd5, 32'd3, 4'd1); bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b1;
        #1;
        chk("t1_req0_ready", {31'd0, bus.req0_ready}, 32'd1);
        chk("t1_req1_ready", {31'd0, bus.req1_ready}, 32'd0);
        chk("t1_alu_op1", bus.alu_op1, 32'd5);
        chk("t1_alu_op2", bus.alu_op2, 32'd3);
        chk("t1_alu_ctrl", {28'd0, bus.alu_ctrl}, 32'd1);
        q0.push_back(32'd2);
        tick();
        bus.req0_valid = 1'b0;
        #1;
        chk("t1_rsp0_valid", {31'd0, bus.rsp0_valid}, 32'd1);
        chk("t1_idle_alu_ctrl", {28'd0, bus.alu_ctrl}, 32'd0);
        tick();
        chk("t1_rsp0_drop", {31'd0, bus.rsp0_valid}, 32'd0);

        // Contention from reset: grants alternate 0,1,0,1.
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        drive0(1'b1, 32'd1, 32'd1, 4'd0);
        drive1(1'b1, 32'd6, 32'd3, 4'd4);
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("t2_req0_ready", {31'd0, bus.req0_ready}, (k % 2 == 0) ? 32'd1 : 32'd0);
            chk("t2_req1_ready", {31'd0, bus.req1_ready}, (k % 2 == 1) ? 32'd1 : 32'd0);
            if (k % 2 == 0) q0.push_back(32'd2); else q1.push_back(32'd5);
            tick();
        end
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        tick();

        // Backpressure on slot 1 while req0 streams.
        bus.rsp1_ready = 1'b0;
        drive1(1'b1, 32'd7, 32'd8, 4'd0);
        #1;
        chk("t3_req1_first", {31'd0, bus.req1_ready}, 32'd1);
        q1.push_back(32'd15);
        tick();
        drive1(1'b1, 32'd2, 32'd2, 4'd0);
        drive0(1'b1, 32'd9, 32'd4, 4'd1);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("t3_req1_stall", {31'd0, bus.req1_ready}, 32'd0);
            chk("t3_req0_go", {31'd0, bus.req0_ready}, 32'd1);
            chk("t3_rsp1_hold", bus.rsp1_data, 32'd15);
            q0.push_back(32'd5);
            tick();
        end
        bus.req0_valid = 1'b0; bus.rsp1_ready = 1'b1;
        #1;
        chk("t3_req1_release", {31'd0, bus.req1_ready}, 32'd1);
        q1.push_back(32'd4);
        tick();
        bus.req1_valid = 1'b0;
        tick(); tick();

        // Drain + refill of slot 0 with SLT -1 < 0.
        drive0(1'b1, 32'd5, 32'd3, 4'd1);
        #1; q0.push_back(32'd2);
        tick();
        drive0(1'b1, 32'hFFFF_FFFF, 32'd0, 4'd5);
        #1;
        chk("t4_req0_ready", {31'd0, bus.req0_ready}, 32'd1);
        q0.push_back(32'd1);
        tick();
        bus.req0_valid = 1'b0;
        #1;
        chk("t4_rsp0_stays", {31'd0, bus.rsp0_valid}, 32'd1);
        tick();
        chk("t4_rsp0_empty", {31'd0, bus.rsp0_valid}, 32'd0);

        // Reset mid-flight: slot 1 loaded and unconsumed, prio left pointing at req1.
        bus.rsp1_ready = 1'b0;
        drive1(1'b1, 32'd3, 32'd4, 4'd0);
        #1; chk("t5_req1_ready", {31'd0, bus.req1_ready}, 32'd1);
        tick();
        bus.req1_valid = 1'b0;
        drive0(1'b1, 32'd2, 32'd2, 4'd0);
        #1; chk("t5_req0_ready", {31'd0, bus.req0_ready}, 32'd1);
        q0.push_back(32'd4);
        tick();
        bus.req0_valid = 1'b0;
        #1; chk("t5_rsp1_loaded", bus.rsp1_data, 32'd7);
        #3; rst_n = 1'b0;
        #1;
        chk("t5_rst_rsp1_valid", {31'd0, bus.rsp1_valid}, 32'd0);
        chk("t5_rst_rsp1_data", bus.rsp1_data, 32'd0);
        tick();
        rst_n = 1'b1; bus.rsp1_ready = 1'b1;
        drive0(1'b1, 32'd1, 32'd2, 4'd0);
        drive1(1'b1, 32'd6, 32'd3, 4'd4);
        #1;
        chk("t5_tie_req0", {31'd0, bus.req0_ready}, 32'd1);
        chk("t5_tie_req1", {31'd0, bus.req1_ready}, 32'd0);
        q0.push_back(32'd3);
        tick();
        #1; chk("t5_next_req1", {31'd0, bus.req1_ready}, 32'd1);
        q1.push_back(32'd5);
        tick();
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        tick();

        // Undefined control code passes through; reference ALU returns 0.
        drive0(1'b1, 32'd5, 32'd5, 4'hF);
        #1; chk("t6_alu_ctrl", {28'd0, bus.alu_ctrl}, 32'd15);
        q0.push_back(32'd0);
        tick();
        bus.req0_valid = 1'b0;
        tick();

`ifdef ALU_ARB_PERF_EN
        // Counters: 3 grants to req0, 2 to req1, 4 stall cycles, then saturation.
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        drive0(1'b1, 32'd1, 32'd1, 4'd0);
        drive1(1'b1, 32'd6, 32'd3, 4'd4);
        for (int k = 0; k < 4; k++) begin
            #1;
            if (k % 2 == 0) q0.push_back(32'd2); else q1.push_back(32'd5);
            tick();
        end
        bus.req1_valid = 1'b0;
        #1; q0.push_back(32'd2);
        tick();
        bus.req0_valid = 1'b0;
        #1;
        chk("perf_grant0", {16'd0, grant0_cnt}, 32'd3);
        chk("perf_grant1", {16'd0, grant1_cnt}, 32'd2);
        chk("perf_stall", {16'd0, stall_cnt}, 32'd4);
        tick();
        drive0(1'b1, 32'd0, 32'd0, 4'd0);
        for (int k = 0; k < 70000; k++) begin
            q0.push_back(32'd0);
            tick();
        end
        bus.req0_valid = 1'b0;
        #1;
        chk("perf_grant0_sat", {16'd0, grant0_cnt}, 32'h0000_FFFF);
        chk("perf_grant1_hold", {16'd0, grant1_cnt}, 32'd2);
        tick();
`endif

        tick(); tick();
        chk("q0_empty", q0.size(), 32'd0);
        chk("q1_empty", q1.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
